detect_load_sched: RTL and testbench
====================================

# detect_load_sched

Controller for the calibrated switching-load bank used in trojan-detection characterisation. It accepts one configuration per run through a valid/ready handshake and drives a 64-bit load register bank for a programmed number of cycles. The bank pattern is all-zero baseline, constant, toggling, or pseudo-random from a 20-bit LFSR, so power-analysis benches can measure detection sensitivity against a known, repeatable injected signature. It sits between the bench/host configuration path and the load bank.

## Interface
- LFSR_W, 20, LFSR width (fixed by the polynomial x^20+x^17+1)
- CNT_W, 16, run-length counter width
- clk  in  1  rising-edge clock; single clock domain
- rst  in  1  synchronous, active-high reset
- cfg_valid  in  1  configuration offered
- cfg_ready  out  1  high only in IDLE; transfer when cfg_valid & cfg_ready at a rising edge
- cfg_mode  in  2  0=baseline (zeros), 1=constant, 2=LFSR, 3=toggle
- cfg_mask  in  8  group enable; group i drives load[8i+7:8i]
- cfg_seed  in  LFSR_W  LFSR seed (0 is replaced by 20'h00001)
- cfg_cycles  in  CNT_W  run length N
- abort  in  1  terminate the current run early
- load  out  64  registered load-bank drive
- busy  out  1  high in ARM, RUN and DONE
- done  out  1  one-cycle pulse in DONE
- aborted  out  1  valid with done; high if the run ended by abort

## Operation
- FSM states: IDLE -> ARM -> RUN -> DONE -> IDLE.
- IDLE: cfg_ready=1. On handshake, capture mode, mask and cycles; go to ARM.
- ARM: load the LFSR with the seed, or 20'h00001 if the seed is 0. Set remaining=N.
- ARM exit: go to RUN if N>0, otherwise to DONE.
- RUN: output pattern p(j) for j=0..N-1, then go to DONE after the Nth cycle.
- Group drive: load[8i+7:8i] = {8{p(j)[i] & mask[i]}}.
- Pattern by mode:
  - mode 0: p=8'h00.
  - mode 1: p=8'hFF.
  - mode 2: p=lfsr[7:0], then step lfsr <= {lfsr[18:0], lfsr[19]^lfsr[16]}. p(0) uses the seed.
  - mode 3: p=8'hFF for even j, 8'h00 for odd j.
- DONE: load=0, done=1, aborted as recorded; return to IDLE.
- abort in ARM or RUN: next state DONE with aborted=1; remaining cycles are dropped.
- abort in IDLE or DONE is ignored; aborted is cleared at the next handshake.
- Configuration inputs are sampled only at the handshake. Changes while busy have no effect.
- The LFSR never holds 0.

## Timing
- Reset (any state, including mid-run) takes effect at the next edge:
  - state=IDLE, load=0, busy=0, done=0, aborted=0, cfg_ready=1.
  - LFSR=20'h00001, counter=0.
- Cycle numbering: handshake in cycle 0.
- Cycle 1: ARM, load=0, busy=1.
- Cycles 2..N+1: RUN, load=pattern(j).
- Cycle N+2: DONE, load=0, done=1.
- Cycle N+3: IDLE, cfg_ready=1. The earliest next handshake is cycle N+3.
- N=0: DONE in cycle 2, no nonzero load.
- Abort asserted in cycle k (ARM or RUN): DONE in cycle k+1. Load is 0 from cycle k+1.
- The counter decrements once per RUN cycle. N=65535 runs exactly 65535 cycles; there is no wrap.
- load is a registered output; there is no combinational path from inputs to load, done or busy.
- cfg_ready is combinational from state only.

## Structure
- Package detect_load_pkg holds:
  - mode encoding (MODE_BASE, MODE_CONST, MODE_LFSR, MODE_TOGGLE);
  - state enum;
  - LFSR_W, tap positions (19, 16) and LFSR_SAFE_SEED=20'h00001;
  - CNT_W and the group width (8).
- Sub-module lfsr20: ports clk, rst, seed_load, seed, step, state. Zero-seed substitution happens inside it.
- Top level holds the FSM, the counter and pattern select, and the 64-bit load register.

## Test plan
- Seed 20'h00001, mode 2, mask FF, N=3: load in cycles 2–4 = 64'h00000000000000FF, 64'h000000000000FF00, 64'h0000000000FF0000. done=1 in cycle 5, aborted=0.
- Mode 3, mask 8'h0F, N=4: load = 64'h00000000FFFFFFFF, 0, 64'h00000000FFFFFFFF, 0. cfg_ready=0 through cycle 6 and 1 in cycle 7.
- Mode 1, N=0: done in cycle 2, load stays 0, busy high in cycles 1–2 only.
- Mode 1, mask FF, N=100, abort in cycle 10: load=64'hFFFFFFFFFFFFFFFF for cycles 2–10, 0 from cycle 11. done=aborted=1 in cycle 11.
- Seed 0, mode 2, mask 8'h01, N=2: behaves as seed 1, giving load 64'h00000000000000FF then 0.
- rst in cycle 5 of an N=20 run: cycle 6 shows IDLE, load=0, busy=0, done=0. A new handshake in cycle 6 is accepted normally.

Source files
------------

// File: rtl/detect_load_pkg.sv
// Shared constants, encodings and LFSR helpers for the calibrated switching-load
// bank controller.
package detect_load_pkg;

    localparam int LFSR_W      = 20;
    localparam int CNT_W       = 16;
    localparam int GROUP_W     = 8;
    localparam int N_GROUPS    = 8;
    localparam int LOAD_W      = GROUP_W * N_GROUPS;
    localparam int LFSR_TAP_HI = 19;
    localparam int LFSR_TAP_LO = 16;
    localparam logic [LFSR_W-1:0] LFSR_SAFE_SEED = 20'h00001;

    typedef enum logic [1:0] {
        MODE_BASE   = 2'd0,
        MODE_CONST  = 2'd1,
        MODE_LFSR   = 2'd2,
        MODE_TOGGLE = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // An all-zero register is the lock-up state of this LFSR, so it is never loaded.
    function automatic logic [LFSR_W-1:0] lfsr_safe(input logic [LFSR_W-1:0] s);
        if (s == {LFSR_W{1'b0}}) begin
            return LFSR_SAFE_SEED;
        end else begin
            return s;
        end
    endfunction

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO]};
    endfunction

    function automatic logic [GROUP_W-1:0] lfsr_byte(input logic [LFSR_W-1:0] s);
        return s[GROUP_W-1:0];
    endfunction

endpackage

// File: rtl/detect_load_sched_lfsr20.sv
// 20-bit Fibonacci LFSR (x^20+x^17+1) with seed load; a zero seed is replaced
// by the safe seed so the register can never lock up.
module lfsr20
    import detect_load_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              step,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] base_s;

    // Seed load and step in the same cycle yields the seed already advanced once.
    always_comb begin
        if (seed_load) begin
            base_s = lfsr_safe(seed);
        end else begin
            base_s = state;
        end
    end

    // LFSR register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LFSR_SAFE_SEED;
        end else if (step) begin
            state <= lfsr_next(base_s);
        end else if (seed_load) begin
            state <= base_s;
        end else begin
            state <= state;
        end
    end

endmodule

// File: rtl/detect_load_sched.sv
// Load-bank run controller: accepts one configuration, then drives a 64-bit
// registered load pattern for N cycles and reports completion or abort.
module detect_load_sched
    import detect_load_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [1:0]         cfg_mode,
    input  logic [7:0]         cfg_mask,
    input  logic [LFSR_W-1:0]  cfg_seed,
    input  logic [CNT_W-1:0]   cfg_cycles,
    input  logic               abort,
    output logic [LOAD_W-1:0]  load,
    output logic               busy,
    output logic               done,
    output logic               aborted
);

    state_t              state_r;
    mode_t               mode_r;
    logic [N_GROUPS-1:0] mask_r;
    logic [LFSR_W-1:0]   seed_r;
    logic [CNT_W-1:0]    cycles_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                phase_r;
    logic [LFSR_W-1:0]   lfsr_state_s;
    logic [LFSR_W-1:0]   pat_src_s;
    logic [GROUP_W-1:0]  pat_s;
    logic [LOAD_W-1:0]   drive_s;
    logic                seed_load_s;
    logic                step_s;

    assign cfg_ready   = (state_r == ST_IDLE);
    assign seed_load_s = (state_r == ST_ARM);
    assign step_s      = (state_r == ST_ARM) || (state_r == ST_RUN);

    lfsr20 u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .seed_load (seed_load_s),
        .seed      (seed_r),
        .step      (step_s),
        .state     (lfsr_state_s)
    );

    // Next load value: computed one cycle ahead, so ARM supplies p(0) from the seed.
    always_comb begin
        if (state_r == ST_ARM) begin
            pat_src_s = lfsr_safe(seed_r);
        end else begin
            pat_src_s = lfsr_state_s;
        end
        case (mode_r)
            MODE_BASE:   pat_s = 8'h00;
            MODE_CONST:  pat_s = 8'hFF;
            MODE_LFSR:   pat_s = lfsr_byte(pat_src_s);
            MODE_TOGGLE: pat_s = phase_r ? 8'h00 : 8'hFF;
            default:     pat_s = 8'h00;
        endcase
        drive_s = {LOAD_W{1'b0}};
        for (int i = 0; i < N_GROUPS; i++) begin
            drive_s[i*GROUP_W +: GROUP_W] = {GROUP_W{pat_s[i] & mask_r[i]}};
        end
    end

    // Run FSM with registered load, busy, done and aborted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            mode_r   <= MODE_BASE;
            mask_r   <= 8'h00;
            seed_r   <= {LFSR_W{1'b0}};
            cycles_r <= {CNT_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            phase_r  <= 1'b0;
            load     <= {LOAD_W{1'b0}};
            busy     <= 1'b0;
            done     <= 1'b0;
            aborted  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    load <= {LOAD_W{1'b0}};
                    if (cfg_valid) begin
                        mode_r   <= mode_t'(cfg_mode);
                        mask_r   <= cfg_mask;
                        seed_r   <= cfg_seed;
                        cycles_r <= cfg_cycles;
                        phase_r  <= 1'b0;
                        aborted  <= 1'b0;
                        busy     <= 1'b1;
                        state_r  <= ST_ARM;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_ARM: begin
                    phase_r <= 1'b1;
                    if (abort) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        load    <= {LOAD_W{1'b0}};
                        aborted <= 1'b1;
                        done    <= 1'b1;
                        state_r <= ST_DONE;
                    end else if (cycles_r != {CNT_W{1'b0}}) begin
                        cnt_r   <= cycles_r;
                        load    <= drive_s;
                        state_r <= ST_RUN;
                    end else begin
                        cnt_r   <= cycles_r;
                        load    <= {LOAD_W{1'b0}};
                        done    <= 1'b1;
                        state_r <= ST_DONE;
                    end
                end
                ST_RUN: begin
                    phase_r <= ~phase_r;
                    // cnt_r counts the RUN cycles still to show, including this one.
                    if (abort) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        load    <= {LOAD_W{1'b0}};
                        aborted <= 1'b1;
                        done    <= 1'b1;
                        state_r <= ST_DONE;
                    end else if (cnt_r == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        load    <= {LOAD_W{1'b0}};
                        done    <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r   <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                        load    <= drive_s;
                        state_r <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    load    <= {LOAD_W{1'b0}};
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    load    <= {LOAD_W{1'b0}};
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_detect_load_sched.sv
// Scoreboard bench for detect_load_sched: per-cycle expected outputs are queued
// from a reference model when each run is launched, then popped and compared.
module tb_detect_load_sched;

    logic        clk;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_mode;
    logic [7:0]  cfg_mask;
    logic [19:0] cfg_seed;
    logic [15:0] cfg_cycles;
    logic        abort;
    logic [63:0] load;
    logic        busy;
    logic        done;
    logic        aborted;

    typedef struct packed {
        logic [63:0] load;
        logic        busy;
        logic        done;
        logic        aborted;
        logic        ready;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   failures;

    detect_load_sched dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_mode   (cfg_mode),
        .cfg_mask   (cfg_mask),
        .cfg_seed   (cfg_seed),
        .cfg_cycles (cfg_cycles),
        .abort      (abort),
        .load       (load),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] expand(input logic [7:0] p, input logic [7:0] m);
        logic [63:0] r;
        r = 64'd0;
        for (int i = 0; i < 8; i++) begin
            r[i*8 +: 8] = {8{p[i] & m[i]}};
        end
        return r;
    endfunction

    // Starts at the falling edge of the handshake cycle (cycle 0) and ends at
    // the falling edge of the first IDLE cycle afterwards.
    task automatic run(input int mode, input logic [7:0] mask, input logic [19:0] seed,
                       input int n, input int abort_k, input int rst_k, input bit hs_abort);
        logic [19:0] lf;
        logic [7:0]  p;
        int          end_c;
        int          last;
        bit          abt;
        exp_t        e;
        lf    = (seed == 20'd0) ? 20'h00001 : seed;
        abt   = (abort_k != 0);
        end_c = abt ? abort_k + 1 : n + 2;
        last  = (rst_k != 0) ? rst_k + 1 : end_c + 1;
        for (int c = 1; c <= last; c++) begin
            e = '{load: 64'd0, busy: 1'b0, done: 1'b0, aborted: 1'b0, ready: 1'b1};
            if (rst_k != 0 && c == rst_k + 1) begin
                e.aborted = 1'b0;
            end else if (c <= end_c) begin
                e.busy  = 1'b1;
                e.ready = 1'b0;
                if (c == end_c) begin
                    e.done    = 1'b1;
                    e.aborted = abt;
                end else if (c >= 2) begin
                    case (mode)
                        0:       p = 8'h00;
                        1:       p = 8'hFF;
                        2:       p = lf[7:0];
                        default: p = ((c - 2) % 2 == 0) ? 8'hFF : 8'h00;
                    endcase
                    lf = {lf[18:0], lf[19] ^ lf[16]};
                    e.load = expand(p, mask);
                end
            end else begin
                e.aborted = abt;
            end
            exp_q.push_back(e);
        end

        check_val("hs_ready", {63'd0, cfg_ready}, 64'd1);
        cfg_valid  = 1'b1;
        cfg_mode   = mode[1:0];
        cfg_mask   = mask;
        cfg_seed   = seed;
        cfg_cycles = n[15:0];
        abort      = hs_abort;
        for (int c = 1; c <= last; c++) begin
            @(posedge clk);
            @(negedge clk);
            cfg_valid  = 1'b0;
            cfg_mode   = 2'($urandom_range(0, 3));
            cfg_mask   = 8'($urandom);
            cfg_seed   = 20'($urandom);
            cfg_cycles = 16'($urandom);
            abort      = (c == abort_k);
            rst        = (c == rst_k);
            if (exp_q.size() == 0) begin
                check_val("queue_empty", 64'd0, 64'd1);
            end else begin
                e = exp_q.pop_front();
                check_val($sformatf("load_c%0d", c), load, e.load);
                check_val($sformatf("busy_c%0d", c), {63'd0, busy}, {63'd0, e.busy});
                check_val($sformatf("done_c%0d", c), {63'd0, done}, {63'd0, e.done});
                check_val($sformatf("aborted_c%0d", c), {63'd0, aborted}, {63'd0, e.aborted});
                check_val($sformatf("ready_c%0d", c), {63'd0, cfg_ready}, {63'd0, e.ready});
            end
        end
        abort = 1'b0;
        rst   = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        cfg_valid  = 1'b0;
        cfg_mode   = 2'd0;
        cfg_mask   = 8'h00;
        cfg_seed   = 20'd0;
        cfg_cycles = 16'd0;
        abort      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_val("rst_load", load, 64'd0);
        check_val("rst_busy", {63'd0, busy}, 64'd0);
        check_val("rst_done", {63'd0, done}, 64'd0);
        check_val("rst_aborted", {63'd0, aborted}, 64'd0);

        run(2, 8'hFF, 20'h00001, 3, 0, 0, 1'b0);
        run(3, 8'h0F, 20'h12345, 4, 0, 0, 1'b0);
        run(1, 8'hFF, 20'h00000, 0, 0, 0, 1'b0);
        run(1, 8'hFF, 20'h00000, 100, 10, 0, 1'b0);
        run(2, 8'h01, 20'h00000, 2, 0, 0, 1'b0);
        run(1, 8'hFF, 20'h00007, 5, 1, 0, 1'b0);
        run(0, 8'hFF, 20'h00003, 5, 0, 0, 1'b1);
        run(2, 8'hA5, 20'h31C4B, 20, 0, 5, 1'b0);
        run(1, 8'h3C, 20'h00009, 3, 0, 0, 1'b0);
        run(2, 8'($urandom), 20'($urandom), 30, 0, 0, 1'b0);
        run(3, 8'hFF, 20'h00000, 7, 5, 0, 1'b0);

        check_val("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
